// File: rtl/hedios_uart_rx.sv
// hedios_uart_rx: 8N1 UART receiver with a line synchroniser, mid-bit sampling,
// stop-bit check and a one-byte holding register on a valid/ready handshake.
// Framing and overrun errors are reported as single-cycle pulses.
module hedios_uart_rx #(
  parameter int CLK_RATE    = 100_000_000,
  parameter int BAUD_RATE   = 1_000_000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_line,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CLKS_PER_BIT = CLK_RATE / BAUD_RATE;
  localparam int HALF         = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  // Too few clocks per bit leaves no room for a meaningful mid-bit sample.
  generate
    if (CLKS_PER_BIT < 4) begin : g_bad_rate
      $error("hedios_uart_rx: CLKS_PER_BIT must be at least 4");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("hedios_uart_rx: SYNC_STAGES must be at least 2");
    end
  endgenerate

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;
  logic [2:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [2:0]             bit_q, bit_d;
  logic [7:0]             shift_q, shift_d;
  logic                   done_q, done_d;
  logic                   ferr_q, ferr_d;
  logic [7:0]             data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   ovr_q, ovr_d;

  assign rxs = sync_q[SYNC_STAGES-1];

  // Synchroniser chain, preset to idle-high so reset release cannot look like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_line};
    end
  end

  // Frame FSM: start validation, data sampling, stop check and break wait.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rxs) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          bit_d = 3'd0;
          // A line that is high again at mid start bit was only a glitch.
          state_d = rxs ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_M1) begin
          cnt_d          = '0;
          shift_d[bit_q] = rxs;
          bit_d          = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt_q == BIT_M1) begin
          cnt_d = '0;
          // Returning to IDLE mid stop bit lets a back-to-back start edge be caught.
          if (rxs) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        cnt_d = '0;
        if (rxs) state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM and shift register state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  // Holding register: load on delivery when free or being drained, else flag overrun.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    if (done_q) begin
      if (!valid_q || ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  // Holding register and overrun pulse state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_hedios_uart_rx.sv
// tb_hedios_uart_rx: scenario tasks plus a randomized frame stream checked
// against a queue-based model of what the line should deliver.
module tb_hedios_uart_rx;

  localparam int CPB = 100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_line = 1'b1;
  logic       ready = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  // monitor state
  logic [7:0] got_q[$];
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  int         cyc = 0;
  int         valid_rise_cyc = -1;
  int         stab_viol = 0;
  logic       prev_valid = 1'b0;
  logic       prev_ready = 1'b0;
  logic [7:0] prev_data = 8'h00;

  hedios_uart_rx #(
    .CLK_RATE(100_000_000),
    .BAUD_RATE(1_000_000),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx_line(rx_line),
    .data(data),
    .valid(valid),
    .ready(ready),
    .frame_err(frame_err),
    .overrun(overrun),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL timeout: simulation exceeded time limit (actual running, required finished)");
    $fatal(1, "timeout");
  end

  // Observes the handshake at the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid && ready) got_q.push_back(data);
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (valid && !prev_valid) valid_rise_cyc = cyc;
      if (prev_valid && !prev_ready && (!valid || data !== prev_data)) stab_viol++;
    end
    prev_valid = valid;
    prev_ready = ready;
    prev_data  = data;
    cyc++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_mon();
    got_q.delete();
    fe_cnt = 0;
    ov_cnt = 0;
    valid_rise_cyc = -1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    $display("tx frame byte=%02h stop=%0b", b, stop_bit);
    rx_line = 1'b0;
    step(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_line = b[i];
      step(CPB);
    end
    rx_line = stop_bit;
    step(CPB);
  endtask

  function automatic logic [7:0] got_at(input int i);
    logic [7:0] r;
    r = 8'hxx;
    if (i < got_q.size()) r = got_q[i];
    return r;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    step(3);
    n_cmp++; if (data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %02h want 00", data); end
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", valid); end
    n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst_n = 1'b1;
    step(5);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL release_busy: got %b want 0", busy); end
  endtask

  task automatic test_basic();
    int t0;
    int lat;
    clear_mon();
    t0 = cyc;
    send_frame(8'hA5, 1'b1);
    step(50);
    lat = valid_rise_cyc - t0;
    $display("rx byte=%02h latency=%0d", got_at(0), lat);
    n_cmp++; if (got_q.size() !== 1) begin n_err++; $display("FAIL basic_count: got %0d want 1", got_q.size()); end
    n_cmp++; if (got_at(0) !== 8'hA5) begin n_err++; $display("FAIL basic_data: got %02h want a5", got_at(0)); end
    n_cmp++; if (fe_cnt !== 0) begin n_err++; $display("FAIL basic_frame_err: got %0d want 0", fe_cnt); end
    n_cmp++; if (ov_cnt !== 0) begin n_err++; $display("FAIL basic_overrun: got %0d want 0", ov_cnt); end
    n_cmp++; if (lat < 945 || lat > 960) begin n_err++; $display("FAIL basic_latency: got %0d want 945..960", lat); end
  endtask

  task automatic test_glitch();
    int k;
    clear_mon();
    rx_line = 1'b0;
    step(30);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL glitch_busy_high: got %b want 1", busy); end
    rx_line = 1'b1;
    k = 0;
    while (busy !== 1'b0 && k < 60) begin
      step(1);
      k++;
    end
    $display("glitch busy cleared after %0d clk", 30 + k);
    n_cmp++; if (30 + k > 60) begin n_err++; $display("FAIL glitch_busy_return: got %0d clk want <=60", 30 + k); end
    step(1100);
    n_cmp++; if (got_q.size() !== 0) begin n_err++; $display("FAIL glitch_no_valid: got %0d bytes want 0", got_q.size()); end
    n_cmp++; if (fe_cnt !== 0) begin n_err++; $display("FAIL glitch_no_frame_err: got %0d want 0", fe_cnt); end
  endtask

  task automatic test_frame_err();
    clear_mon();
    send_frame(8'h3C, 1'b0);
    step(200);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL ferr_busy_in_break: got %b want 1", busy); end
    n_cmp++; if (fe_cnt !== 1) begin n_err++; $display("FAIL ferr_pulse_count: got %0d want 1", fe_cnt); end
    rx_line = 1'b1;
    step(6);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ferr_busy_release: got %b want 0", busy); end
    n_cmp++; if (got_q.size() !== 0) begin n_err++; $display("FAIL ferr_no_byte: got %0d want 0", got_q.size()); end
    send_frame(8'h81, 1'b1);
    step(100);
    $display("rx byte=%02h after framing error", got_at(0));
    n_cmp++; if (got_at(0) !== 8'h81 || got_q.size() !== 1) begin n_err++; $display("FAIL ferr_recover: got %02h (n=%0d) want 81 (n=1)", got_at(0), got_q.size()); end
  endtask

  task automatic test_overrun();
    clear_mon();
    ready = 1'b0;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    step(100);
    n_cmp++; if (valid !== 1'b1) begin n_err++; $display("FAIL ovr_valid_held: got %b want 1", valid); end
    n_cmp++; if (data !== 8'h11) begin n_err++; $display("FAIL ovr_data_held: got %02h want 11", data); end
    n_cmp++; if (ov_cnt !== 1) begin n_err++; $display("FAIL ovr_pulse_count: got %0d want 1", ov_cnt); end
    ready = 1'b1;
    step(1);
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL ovr_valid_drop: got %b want 0", valid); end
    n_cmp++; if (data !== 8'h11) begin n_err++; $display("FAIL ovr_data_after: got %02h want 11", data); end
    n_cmp++; if (got_at(0) !== 8'h11 || got_q.size() !== 1) begin n_err++; $display("FAIL ovr_accepted: got %02h (n=%0d) want 11 (n=1)", got_at(0), got_q.size()); end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    ready = 1'b0;
    send_frame(8'h55, 1'b1);
    step(100);
    n_cmp++; if (valid !== 1'b1 || data !== 8'h55) begin n_err++; $display("FAIL b2b_first: got v=%b d=%02h want v=1 d=55", valid, data); end
    fork
      send_frame(8'h66, 1'b1);
      begin
        int k;
        k = 0;
        while (busy !== 1'b1 && k < 20) begin step(1); k++; end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_start_wait: got busy=%b want 1", busy); end
        k = 0;
        while (busy !== 1'b0 && k < 1100) begin step(1); k++; end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_stop_wait: got busy=%b want 0", busy); end
        ready = 1'b1;
        step(1);
        ready = 1'b0;
        n_cmp++; if (data !== 8'h66) begin n_err++; $display("FAIL b2b_data: got %02h want 66", data); end
        n_cmp++; if (valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid: got %b want 1", valid); end
      end
    join
    n_cmp++; if (ov_cnt !== 0) begin n_err++; $display("FAIL b2b_overrun: got %0d want 0", ov_cnt); end
    ready = 1'b1;
    step(2);
    n_cmp++; if (got_at(0) !== 8'h55 || got_at(1) !== 8'h66 || got_q.size() !== 2) begin n_err++; $display("FAIL b2b_stream: got %02h,%02h (n=%0d) want 55,66 (n=2)", got_at(0), got_at(1), got_q.size()); end
  endtask

  task automatic test_reset_mid();
    clear_mon();
    ready = 1'b1;
    fork
      send_frame(8'hF0, 1'b1);
      begin
        step(5 * CPB + 50);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (data !== 8'h00 || valid !== 1'b0 || busy !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0) begin
          n_err++;
          $display("FAIL midrst_outputs: got d=%02h v=%b b=%b fe=%b ov=%b want all 0", data, valid, busy, frame_err, overrun);
        end
        step(10);
        rst_n = 1'b1;
      end
    join
    send_frame(8'h0F, 1'b1);
    step(100);
    $display("rx byte=%02h after mid-frame reset", got_at(0));
    n_cmp++; if (got_at(0) !== 8'h0F || got_q.size() !== 1) begin n_err++; $display("FAIL midrst_only_0f: got %02h (n=%0d) want 0f (n=1)", got_at(0), got_q.size()); end
    n_cmp++; if (fe_cnt !== 0) begin n_err++; $display("FAIL midrst_frame_err: got %0d want 0", fe_cnt); end
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    int         exp_fe;
    logic [7:0] b;
    logic       good;
    clear_mon();
    exp_fe = 0;
    ready = 1'b1;
    for (int n = 0; n < 20; n++) begin
      b = 8'($urandom_range(0, 255));
      good = ($urandom_range(0, 4) != 0);
      send_frame(b, good);
      if (good) begin
        exp_q.push_back(b);
        step($urandom_range(0, 150));
      end else begin
        exp_fe++;
        step($urandom_range(0, 100));
        rx_line = 1'b1;
        step($urandom_range(4, 150));
      end
    end
    step(100);
    n_cmp++; if (got_q.size() !== exp_q.size()) begin n_err++; $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++; if (got_at(i) !== exp_q[i]) begin n_err++; $display("FAIL rand_byte[%0d]: got %02h want %02h", i, got_at(i), exp_q[i]); end
    end
    n_cmp++; if (fe_cnt !== exp_fe) begin n_err++; $display("FAIL rand_frame_err: got %0d want %0d", fe_cnt, exp_fe); end
    n_cmp++; if (ov_cnt !== 0) begin n_err++; $display("FAIL rand_overrun: got %0d want 0", ov_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    test_random();
    n_cmp++; if (stab_viol !== 0) begin n_err++; $display("FAIL handshake_stability: got %0d violations want 0", stab_viol); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
